// File: rtl/vga_cmd_engine.sv
// Command-driven VGA register engine: a small command FIFO feeds an FSM that
// updates display registers and performs blank-gated framebuffer writes.
module vga_cmd_engine #(
    parameter int ADDR_W   = 14,
    parameter int RAM_SIZE = 'h1800,
    parameter int H_CHARS  = 80,
    parameter int FIFO_AW  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [2:0]        WR_REG,
    input  logic [7:0]        WR_DATA,
    output logic              FULL,
    input  logic [2:0]        RD_REG,
    output logic [7:0]        RD_DATA,
    input  logic              DE,
    input  logic              VSYNC_PULSE,
    input  logic              HSYNC_PULSE,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [7:0]        FB_DATA,
    output logic [1:0]        MODE,
    output logic [7:0]        HSCROLL,
    output logic [7:0]        VSCROLL,
    output logic [ADDR_W-1:0] CURSOR_ADDR,
    output logic              IRQ
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef logic [ADDR_W:0] wide_t;
    localparam wide_t RAM_SZ = wide_t'(RAM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_BLANK,
        S_INC
    } state_t;

    state_t             state;
    logic [10:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push;
    logic               pop;

    logic [2:0]         cmd_reg;
    logic [7:0]         cmd_data;
    logic [7:0]         ctrl;
    logic [7:0]         ien;
    logic [7:0]         intr;
    logic [7:0]         hscroll;
    logic [7:0]         vscroll;
    logic [ADDR_W-1:0]  addr;

    wide_t              step_val;
    wide_t              addr_ext;
    wide_t              addr_wide;
    logic [7:0]         intr_set;
    logic [7:0]         intr_clr;
    logic [7:0]         reg_read;

    assign FULL        = (32'(count) == DEPTH);
    assign push        = WR_EN && !FULL;
    assign pop         = (state == S_FETCH);
    assign MODE        = ctrl[1:0];
    assign HSCROLL     = hscroll;
    assign VSCROLL     = vscroll;
    assign CURSOR_ADDR = addr;
    assign FB_ADDR     = addr;
    assign FB_DATA     = cmd_data;
    // The write lands in the first blanking cycle, so it cannot wait for a register stage.
    assign FB_WE = (state == S_WAIT_BLANK) && !DE && !RESET && ({1'b0, addr} < RAM_SZ);

    always_comb begin
        step_val = '0;
        case (ctrl[6:2])
            5'd1, 5'd2, 5'd3, 5'd4,
            5'd5, 5'd6, 5'd7, 5'd8: step_val = wide_t'(1) << (ctrl[6:2] - 5'd1);
            5'd9:                   step_val = wide_t'(3);
            5'd10:                  step_val = wide_t'(10);
            5'd11:                  step_val = wide_t'(H_CHARS);
            5'd12:                  step_val = wide_t'(2 * H_CHARS);
            5'd13:                  step_val = wide_t'(3 * H_CHARS);
            default:                step_val = '0;
        endcase
    end

    // Address stepping wraps modulo the framebuffer depth in both directions.
    always_comb begin
        addr_ext = {1'b0, addr};
        if (!ctrl[7]) begin
            addr_wide = (addr_ext + step_val >= RAM_SZ) ? addr_ext + step_val - RAM_SZ
                                                        : addr_ext + step_val;
        end else begin
            addr_wide = (addr_ext < step_val) ? addr_ext + RAM_SZ - step_val
                                              : addr_ext - step_val;
        end
    end

    always_comb begin
        intr_set = {VSYNC_PULSE, 5'b0, WR_EN && FULL, HSYNC_PULSE};
        intr_clr = (state == S_EXEC && cmd_reg == 3'd5) ? cmd_data : 8'h00;
        case (RD_REG)
            3'd0:    reg_read = ctrl;
            3'd1:    reg_read = addr[7:0];
            3'd2:    reg_read = 8'(addr >> 8);
            3'd3:    reg_read = (32'(count) > 255) ? 8'hFF : 8'(count);
            3'd4:    reg_read = ien;
            3'd5:    reg_read = intr;
            3'd6:    reg_read = hscroll;
            default: reg_read = vscroll;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {WR_REG, WR_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_reg  <= '0;
            cmd_data <= '0;
            ctrl     <= 8'h05;
            ien      <= '0;
            intr     <= '0;
            hscroll  <= '0;
            vscroll  <= '0;
            addr     <= '0;
            RD_DATA  <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            // A new set event in the same cycle as a write-one-to-clear keeps the flag.
            intr    <= (intr & ~intr_clr) | intr_set;
            IRQ     <= |(intr & ien);
            RD_DATA <= reg_read;

            case (state)
                S_IDLE: begin
                    if (count != '0) state <= S_FETCH;
                end
                S_FETCH: begin
                    {cmd_reg, cmd_data} <= fifo_mem[rd_ptr];
                    state               <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    case (cmd_reg)
                        3'd0:    ctrl               <= cmd_data;
                        3'd1:    addr[7:0]          <= cmd_data;
                        3'd2:    addr[ADDR_W-1:8]   <= cmd_data[ADDR_W-9:0];
                        3'd3:    state              <= S_WAIT_BLANK;
                        3'd4:    ien                <= cmd_data;
                        3'd6:    hscroll            <= cmd_data;
                        3'd7:    vscroll            <= cmd_data;
                        default: ;
                    endcase
                end
                S_WAIT_BLANK: begin
                    if (!DE) state <= S_INC;
                end
                S_INC: begin
                    addr  <= ADDR_W'(addr_wide);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
